// File: rtl/bist_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : bist_response_analyzer
// Brief    : Compacts N_VEC CUT response bits into a SISR and checks the
//            final signature against GOLDEN.
// Revision : 1.0 - initial release
// ============================================================================
module bist_response_analyzer #(
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = '0,
  parameter int              N_VEC  = 4,
  parameter logic [SIG_W-1:0] GOLDEN = '0
) (
  input  logic             CP,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z,
  input  logic             valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int                 c_CNT_W = $clog2(N_VEC + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N_VEC - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SIG_W-1:0]   r_sig, w_sig_nxt;
  logic [c_CNT_W-1:0] r_count, w_count_nxt;
  logic               r_cmp_stage, w_cmp_stage_nxt;
  logic               r_match, w_match_nxt;
  logic               r_done, w_done_nxt;
  logic               r_pass, w_pass_nxt;
  logic               w_fb;
  logic [SIG_W-1:0]   w_sig_step;

  assign w_fb       = r_sig[SIG_W-1] ^ z;
  assign w_sig_step = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

  always_ff @(posedge CP or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sig       <= SEED;
      r_count     <= '0;
      r_cmp_stage <= 1'b0;
      r_match     <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sig       <= w_sig_nxt;
      r_count     <= w_count_nxt;
      r_cmp_stage <= w_cmp_stage_nxt;
      r_match     <= w_match_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sig_nxt       = r_sig;
    w_count_nxt     = r_count;
    w_cmp_stage_nxt = r_cmp_stage;
    w_match_nxt     = r_match;
    w_done_nxt      = r_done;
    w_pass_nxt      = r_pass;
    case (r_state)
      S_IDLE, S_DONE: begin
        // A start wins over a coincident valid: that z is never absorbed.
        if (start) begin
          w_state_nxt = S_COMPACT;
          w_sig_nxt   = SEED;
          w_count_nxt = '0;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_COMPACT: begin
        if (valid) begin
          w_sig_nxt   = w_sig_step;
          w_count_nxt = r_count + c_ONE;
          if (r_count == c_LAST) begin
            w_state_nxt     = S_COMPARE;
            w_cmp_stage_nxt = 1'b0;
          end
        end
      end
      S_COMPARE: begin
        // Equality is registered first so the wide compare stays off the
        // done/pass path; the result lands on the second edge.
        if (!r_cmp_stage) begin
          w_match_nxt     = (r_sig == GOLDEN);
          w_cmp_stage_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = r_match;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (r_state == S_COMPACT) || (r_state == S_COMPARE);
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_bist_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bist_response_analyzer
// Brief    : Table-driven and randomized self-checking bench for the analyzer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bist_response_analyzer;

  localparam int         c_SIG_W  = 4;
  localparam logic [3:0] c_POLY   = 4'h3;
  localparam logic [3:0] c_SEED   = 4'h0;
  localparam int         c_N_VEC  = 4;
  localparam logic [3:0] c_GOLDEN = 4'hE;

  logic       CP = 1'b0;
  logic       rst_n;
  logic       start;
  logic       z;
  logic       valid;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] signature;

  int n_checks = 0;
  int n_fail   = 0;

  bist_response_analyzer #(
    .SIG_W (c_SIG_W),
    .POLY  (c_POLY),
    .SEED  (c_SEED),
    .N_VEC (c_N_VEC),
    .GOLDEN(c_GOLDEN)
  ) dut (
    .CP       (CP),
    .rst_n    (rst_n),
    .start    (start),
    .z        (z),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .signature(signature)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic [3:0]  zs;        // bit i is sample i
    int          gap_len;   // idle cycles before sample index 2
    logic        start_mid; // pulse start with sample index 1
    logic [15:0] steps;     // nibble i = signature after sample i
    logic [3:0]  fin;
    logic        exp_pass;
  } vec_t;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x, reduce mod x^4+POLY.
  function automatic logic [3:0] model_step(input logic [3:0] s, input logic zb);
    int s2;
    logic fb;
    s2 = int'(s) * 2;
    fb = ((s2 / 16) % 2 == 1) ^ zb;
    return 4'(s2 % 16) ^ (fb ? c_POLY : 4'h0);
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    start = 1'b1; valid = 1'b1; z = 1'b1;
    tick();
    start = 1'b0; valid = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_sig"}, 32'(signature), 32'(c_SEED));
    chk({tag, "_start_done"}, 32'(done), 32'd0);
    chk({tag, "_start_pass"}, 32'(pass), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int g = 0; g < v.gap_len; g++) begin
          z = 1'($urandom); valid = 1'b0;
          tick();
          chk({tag, "_gap_sig"}, 32'(signature), 32'(v.steps[7:4]));
        end
      end
      z = v.zs[i]; valid = 1'b1; start = v.start_mid && (i == 1);
      tick();
      valid = 1'b0; start = 1'b0;
      chk({tag, "_step_sig"}, 32'(signature), 32'(v.steps[i*4 +: 4]));
      chk({tag, "_step_busy"}, 32'(busy), 32'd1);
    end
    tick();
    chk({tag, "_cmp_done"}, 32'(done), 32'd0);
    chk({tag, "_cmp_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
    chk({tag, "_final_sig"}, 32'(signature), 32'(v.fin));
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    for (int h = 0; h < 2; h++) begin
      valid = 1'b1; z = 1'($urandom);
      tick();
      chk({tag, "_hold_sig"}, 32'(signature), 32'(v.fin));
      chk({tag, "_hold_done"}, 32'(done), 32'd1);
    end
    valid = 1'b0;
  endtask

  task automatic rand_run(input int idx);
    logic [3:0] exp_sig;
    int n, edges;
    start = 1'b1; valid = 1'b0;
    tick();
    start = 1'b0;
    chk("rand_start_done", 32'(done), 32'd0);
    exp_sig = c_SEED;
    n = 0;
    while (n < c_N_VEC) begin
      valid = ($urandom_range(0, 2) != 0);
      z     = 1'($urandom);
      start = ($urandom_range(0, 5) == 0);
      tick();
      if (valid) begin
        exp_sig = model_step(exp_sig, z);
        n++;
      end
      chk("rand_sig", 32'(signature), 32'(exp_sig));
    end
    edges = 0;
    while (!done && edges < 10) begin
      valid = 1'($urandom); z = 1'($urandom); start = 1'($urandom);
      tick();
      edges++;
    end
    start = 1'b0; valid = 1'b0;
    chk("rand_latency", 32'(edges), 32'd2);
    chk("rand_pass", 32'(pass), 32'(exp_sig == c_GOLDEN));
    chk("rand_final_sig", 32'(signature), 32'(exp_sig));
    valid = 1'b1; z = 1'($urandom);
    tick();
    valid = 1'b0;
    chk("rand_done_hold_sig", 32'(signature), 32'(exp_sig));
    if (idx < 0) $display("unused");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{zs: 4'b1101, gap_len: 0, start_mid: 1'b0, steps: 16'hEF63, fin: 4'hE, exp_pass: 1'b1};
    tbl[1] = '{zs: 4'b0101, gap_len: 0, start_mid: 1'b0, steps: 16'hDF63, fin: 4'hD, exp_pass: 1'b0};
    tbl[2] = '{zs: 4'b1101, gap_len: 3, start_mid: 1'b0, steps: 16'hEF63, fin: 4'hE, exp_pass: 1'b1};
    tbl[3] = '{zs: 4'b1101, gap_len: 1, start_mid: 1'b1, steps: 16'hEF63, fin: 4'hE, exp_pass: 1'b1};
    tbl[4] = '{zs: 4'b0000, gap_len: 0, start_mid: 1'b0, steps: 16'h0000, fin: 4'h0, exp_pass: 1'b0};

    rst_n = 1'b0; start = 1'b0; z = 1'b0; valid = 1'b0;
    tick(); tick();
    chk("reset_sig", 32'(signature), 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      valid = 1'($urandom); z = 1'($urandom);
      tick();
      chk("idle_sig", 32'(signature), 32'h0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    valid = 1'b0;

    // Back-to-back entries also exercise restart from DONE.
    for (int i = 0; i < 5; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset after two samples, between clock edges.
    start = 1'b1;
    tick();
    start = 1'b0;
    z = 1'b1; valid = 1'b1; tick();
    z = 1'b0; tick();
    valid = 1'b0;
    chk("pre_rst_sig", 32'(signature), 32'h6);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_sig", 32'(signature), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; z = 1'($urandom);
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_sig", 32'(signature), 32'h0);
    end
    valid = 1'b0;
    apply_vec(tbl[0], "after_rst");

    for (int r = 0; r < 30; r++) rand_run(r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
